// File: rtl/sm_route_sequencer.sv
// Steps the line follower through a preloaded route of turn codes, counting debounced node crossings.
// Outputs are registered (one-edge latency); no backpressure, the follower consumes error_node/node every cycle.
module sm_route_sequencer #(
    parameter int ROUTE_DEPTH = 16,
    parameter int DEBOUNCE    = 1000,
    parameter int STOP_NODE   = 22,
    parameter int TURN_MAG    = 10
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [1:0] wr_data,
    input  logic [4:0] route_len,
    input  logic       node_detected,
    output logic [7:0] error_node,
    output logic [5:0] node,
    output logic       busy,
    output logic       done,
    output logic [3:0] route_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_AT_NODE, S_DONE} state_t;

    localparam int          CW        = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [4:0]  DEPTH_LEN = 5'(ROUTE_DEPTH);
    localparam logic [5:0]  STOP_VAL  = 6'(STOP_NODE);
    localparam logic [7:0]  TURN_POS  = 8'(TURN_MAG);
    localparam logic [7:0]  TURN_NEG  = 8'(-TURN_MAG);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    len_q, len_d;
    logic [3:0]    idx_q, idx_d;
    logic [5:0]    node_q, node_d;
    logic [7:0]    err_q, err_d;

    logic [1:0]    route_mem [16];

    logic [1:0]    cur_code;
    logic          cur_halt;
    logic          cnt_hit;
    logic          node_entry;
    logic          node_exit;
    logic          last_entry;
    logic [4:0]    start_len;

    function automatic logic [7:0] turn_map(input logic [1:0] code);
        case (code)
            2'b01:   return TURN_POS;
            2'b10:   return TURN_NEG;
            default: return 8'h00;
        endcase
    endfunction

    assign cur_code   = route_mem[idx_q];
    assign cur_halt   = (cur_code == 2'b11);
    assign cnt_hit    = (cnt_q == CNT_LAST);
    assign node_entry = (state_q == S_RUN) && node_detected && cnt_hit;
    assign node_exit  = (state_q == S_AT_NODE) && !node_detected && cnt_hit;
    assign last_entry = (({1'b0, idx_q} + 5'd1) == len_q);
    assign start_len  = (route_len > DEPTH_LEN) ? DEPTH_LEN : route_len;

    // Table is deliberately outside the reset domain so a route survives a reset.
    always_ff @(posedge clk_50) begin
        if (wr_en && !busy) begin
            route_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            node_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            node_q  <= node_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = (start_len == 5'd0) ? S_DONE : S_RUN;
                S_RUN:          if (node_entry) state_d = cur_halt ? S_DONE : S_AT_NODE;
                S_AT_NODE:      if (node_exit) state_d = last_entry ? S_DONE : S_RUN;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        len_d  = len_q;
        idx_d  = idx_q;
        node_d = node_q;
        err_d  = err_q;
        if (abort) begin
            cnt_d  = '0;
            idx_d  = '0;
            node_d = '0;
            err_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    cnt_d = '0;
                    if (start) begin
                        len_d = start_len;
                        idx_d = '0;
                        if (start_len == 5'd0) begin
                            node_d = STOP_VAL;
                            err_d  = '0;
                        end else begin
                            node_d = '0;
                            err_d  = turn_map(route_mem[4'd0]);
                        end
                    end
                end
                S_RUN: begin
                    err_d = turn_map(cur_code);
                    cnt_d = (node_detected && !cnt_hit) ? cnt_q + CW'(1) : '0;
                    if (node_entry) begin
                        node_d = node_q + 6'd1;
                        if (cur_halt) begin
                            node_d = STOP_VAL;
                            err_d  = '0;
                        end
                    end
                end
                S_AT_NODE: begin
                    cnt_d = (!node_detected && !cnt_hit) ? cnt_q + CW'(1) : '0;
                    if (node_exit) begin
                        if (last_entry) begin
                            node_d = STOP_VAL;
                            err_d  = '0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q == S_RUN) || (state_q == S_AT_NODE);
        done       = (state_q == S_DONE);
        error_node = err_q;
        node       = node_q;
        route_idx  = idx_q;
    end

endmodule

// File: tb/tb_sm_route_sequencer.sv
// Randomized and directed checks of sm_route_sequencer against a route-level reference model.
module tb_sm_route_sequencer;

    localparam int D      = 4;
    localparam int DEPTH  = 16;
    localparam int STOP   = 22;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_AT   = 2;
    localparam int M_DONE = 3;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b0, start = 1'b0, abort = 1'b0, wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic [4:0] route_len = '0;
    logic       node_detected = 1'b0;
    logic [7:0] error_node;
    logic [5:0] node;
    logic       busy, done;
    logic [3:0] route_idx;

    always #5 clk_50 = ~clk_50;

    sm_route_sequencer #(.ROUTE_DEPTH(DEPTH), .DEBOUNCE(D), .STOP_NODE(STOP), .TURN_MAG(10)) dut (
        .clk_50(clk_50), .reset(reset), .start(start), .abort(abort),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .route_len(route_len),
        .node_detected(node_detected), .error_node(error_node), .node(node),
        .busy(busy), .done(done), .route_idx(route_idx)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: where we are on the route, how many nodes were crossed,
    // and how long node_detected has held the level we are waiting for.
    int         m_mode = M_IDLE;
    int         m_pos = 0, m_crossed = 0, m_streak = 0, m_len = 0;
    logic [7:0] m_err = 8'h00;
    int         tbl [DEPTH];
    int         seg_left = 0;
    logic       lvl = 1'b0;

    function automatic logic [7:0] tmap(input int code);
        if (code == 1) return 8'h0A;
        if (code == 2) return 8'hF6;
        return 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit was_busy;
        was_busy = (m_mode == M_RUN) || (m_mode == M_AT);
        if (reset) begin
            m_mode = M_IDLE; m_pos = 0; m_crossed = 0; m_streak = 0; m_len = 0; m_err = 0;
        end else begin
            if (abort) begin
                m_mode = M_IDLE; m_pos = 0; m_crossed = 0; m_streak = 0; m_err = 0;
            end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
                m_streak = 0;
                if (start) begin
                    m_len = (int'(route_len) < DEPTH) ? int'(route_len) : DEPTH;
                    m_pos = 0;
                    if (m_len == 0) begin
                        m_mode = M_DONE; m_crossed = STOP; m_err = 0;
                    end else begin
                        m_mode = M_RUN; m_crossed = 0; m_err = tmap(tbl[0]);
                    end
                end
            end else if (m_mode == M_RUN) begin
                m_err = tmap(tbl[m_pos]);
                m_streak = node_detected ? m_streak + 1 : 0;
                if (m_streak == D) begin
                    m_streak = 0;
                    m_crossed++;
                    if (tbl[m_pos] == 3) begin
                        m_mode = M_DONE; m_crossed = STOP; m_err = 0;
                    end else begin
                        m_mode = M_AT;
                    end
                end
            end else begin
                m_streak = node_detected ? 0 : m_streak + 1;
                if (m_streak == D) begin
                    m_streak = 0;
                    if (m_pos + 1 == m_len) begin
                        m_mode = M_DONE; m_crossed = STOP; m_err = 0;
                    end else begin
                        m_pos++;
                        m_mode = M_RUN;
                    end
                end
            end
            if (wr_en && !was_busy) tbl[wr_addr] = int'(wr_data);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_50);
        #1;
        chk("error_node", 32'(error_node), 32'(m_err));
        chk("node", 32'(node), 32'(m_crossed));
        chk("busy", 32'(busy), 32'((m_mode == M_RUN) || (m_mode == M_AT)));
        chk("done", 32'(done), 32'(m_mode == M_DONE));
        chk("route_idx", 32'(route_idx), 32'(m_pos));
        start = 1'b0; abort = 1'b0; wr_en = 1'b0; reset = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 2'(d);
        tick();
    endtask

    task automatic go(input int len);
        start = 1'b1; route_len = 5'(len);
        tick();
    endtask

    task automatic hold(input logic level, input int n);
        for (int k = 0; k < n; k++) begin
            node_detected = level;
            tick();
        end
    endtask

    task automatic cross_node();
        hold(1'b1, D);
        hold(1'b0, D);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) tbl[i] = 0;
        for (int i = 0; i < DEPTH; i++) wr(i, 0);
        reset = 1'b1;
        tick();
        chk("rst_node", 32'(node), 0);
        chk("rst_err", 32'(error_node), 0);
        chk("rst_busy", 32'(busy), 0);

        // Three-entry route: +, -, straight.
        wr(0, 1); wr(1, 2); wr(2, 0);
        go(3);
        chk("t1_err0", 32'(error_node), 32'h0A);
        hold(1'b1, D);
        chk("t1_node1", 32'(node), 1);
        hold(1'b0, D);
        hold(1'b1, 1);
        chk("t1_err1", 32'(error_node), 32'hF6);
        hold(1'b1, D - 1);
        chk("t1_node2", 32'(node), 2);
        hold(1'b0, D);
        hold(1'b1, D);
        chk("t1_node3", 32'(node), 3);
        chk("t1_err2", 32'(error_node), 32'h00);
        hold(1'b0, D);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_stop", 32'(node), STOP);

        // Glitches shorter than the debounce window.
        go(3);
        hold(1'b1, D - 1); hold(1'b0, 1); hold(1'b1, D - 1);
        chk("t2_glitch_node", 32'(node), 0);
        chk("t2_glitch_busy", 32'(busy), 1);
        hold(1'b0, 1); hold(1'b1, D);
        chk("t2_node1", 32'(node), 1);
        abort = 1'b1; tick();

        // Halt entry stops the run at the second node.
        wr(0, 0); wr(1, 3); wr(2, 1);
        go(3);
        cross_node();
        hold(1'b1, D);
        chk("t3_done", 32'(done), 1);
        chk("t3_stop", 32'(node), STOP);
        chk("t3_err", 32'(error_node), 0);

        // Zero-length and over-length routes.
        abort = 1'b1; tick();
        go(0);
        chk("t4_zero_done", 32'(done), 1);
        chk("t4_zero_busy", 32'(busy), 0);
        for (int i = 0; i < DEPTH; i++) wr(i, $urandom_range(0, 2));
        go(20);
        for (int i = 0; i < DEPTH - 1; i++) cross_node();
        chk("t4_15_busy", 32'(busy), 1);
        cross_node();
        chk("t4_16_done", 32'(done), 1);

        // Abort while sitting on node 2; a busy write must be dropped.
        wr(0, 1); wr(1, 2); wr(2, 1); wr(3, 2);
        go(4);
        cross_node();
        hold(1'b1, D);
        wr(0, 0);
        abort = 1'b1; tick();
        chk("t5_node", 32'(node), 0);
        chk("t5_err", 32'(error_node), 0);
        go(4);
        chk("t5_readback", 32'(error_node), 32'h0A);

        // Reset mid-run at node 5, then rerun the same route.
        abort = 1'b1; tick();
        go(16);
        for (int i = 0; i < 5; i++) cross_node();
        reset = 1'b1; tick();
        chk("t6_node", 32'(node), 0);
        chk("t6_busy", 32'(busy), 0);
        go(16);
        chk("t6_rerun_err", 32'(error_node), 32'(tmap(tbl[0])));
        for (int i = 0; i < 3; i++) cross_node();

        // Random traffic with mixed control pulses and writes.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (seg_left == 0) begin
                lvl = ~lvl;
                seg_left = $urandom_range(1, 7);
            end
            node_detected = lvl;
            seg_left--;
            if (r < 20) begin
                start = 1'b1; route_len = 5'($urandom_range(0, 20));
            end else if (r < 28) begin
                abort = 1'b1;
            end else if (r < 32) begin
                start = 1'b1; abort = 1'b1; route_len = 5'($urandom_range(1, 20));
            end else if (r < 35) begin
                reset = 1'b1;
            end else if (r < 70) begin
                wr_en = 1'b1; wr_addr = 4'($urandom); wr_data = 2'($urandom);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
